// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the AES stream self-test blocks.
//   chk_state_t  : golden-checker FSM state encoding
//   keep_mask_eq : byte-masked equality of two beats under a tkeep mask
package aes_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  // Package functions cannot take a type parameter. Callers zero-extend their
  // DATA_W-wide beats to this width. Zero-padded keep bits never cause a
  // mismatch, so one function body serves every beat width up to this limit.
  localparam int KEEP_MAX_W = 1024;
  localparam int KEEP_MAX_B = KEEP_MAX_W / 8;

  // Returns 1 when every byte whose keep bit is set is equal in both beats.
  // An all-zero keep compares equal.
  function automatic logic keep_mask_eq(
    input logic [KEEP_MAX_W-1:0] data,
    input logic [KEEP_MAX_W-1:0] ref_beat,
    input logic [KEEP_MAX_B-1:0] keep
  );
    logic eq;
    eq = 1'b1;
    for (int k = 0; k < KEEP_MAX_B; k++) begin
      if (keep[k] && (data[8*k +: 8] != ref_beat[8*k +: 8])) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/masked_beat_compare.sv
// Combinational byte-masked beat comparator.
//   data     : received beat
//   ref_beat : golden beat
//   keep     : byte-valid mask, bit k covers data[8k+:8]
//   match    : 1 when all kept bytes are equal
module masked_beat_compare
  import aes_stream_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W-1:0]   ref_beat,
  input  logic [DATA_W/8-1:0] keep,
  output logic                match
);

  logic [KEEP_MAX_W-1:0] data_ext;
  logic [KEEP_MAX_W-1:0] ref_ext;
  logic [KEEP_MAX_B-1:0] keep_ext;

  assign data_ext = KEEP_MAX_W'(data);
  assign ref_ext  = KEEP_MAX_W'(ref_beat);
  assign keep_ext = KEEP_MAX_B'(keep);
  assign match    = keep_mask_eq(data_ext, ref_ext, keep_ext);

endmodule

// File: rtl/axis_golden_checker.sv
// AXI-Stream golden-image checker.
// Compares each accepted beat against a golden beat read from an external
// BRAM-style memory (1-cycle read latency, output holds while not enabled).
// Results are counted per frame.
//   start/frame_len         : arm a check of frame_len beats (ignored while busy)
//   ref_addr/ref_en/ref_dout: golden memory read port
//   s_axis_*                : input stream; tready is high only in CHECK
//   busy/done/pass          : progress, one-cycle completion pulse, verdict
//   match_count/mismatch_count/first_err_idx/first_err_valid/len_err : results
module axis_golden_checker
  import aes_stream_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int SKIP_BEATS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   frame_len,
  output logic [ADDR_WIDTH-1:0] ref_addr,
  output logic                  ref_en,
  input  logic [DATA_W-1:0]     ref_dout,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   match_count,
  output logic [ADDR_WIDTH:0]   mismatch_count,
  output logic [ADDR_WIDTH-1:0] first_err_idx,
  output logic                  first_err_valid,
  output logic                  len_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] SKIP_L  = (ADDR_WIDTH+1)'(SKIP_BEATS);

  chk_state_t            state_q, state_n;
  logic [ADDR_WIDTH-1:0] idx_q, idx_n;
  logic [ADDR_WIDTH:0]   eff_len_q, eff_len_n;
  logic [ADDR_WIDTH:0]   match_q, match_n;
  logic [ADDR_WIDTH:0]   mism_q, mism_n;
  logic [ADDR_WIDTH-1:0] fei_q, fei_n;
  logic                  fev_q, fev_n;
  logic                  len_err_q, len_err_n;
  logic                  pass_q, pass_n;
  logic                  done_q, busy_q;

  logic beat_ok;
  logic hs;
  logic last_beat;
  logic counted;

  masked_beat_compare #(.DATA_W(DATA_W)) u_cmp (
    .data     (s_axis_tdata),
    .ref_beat (ref_dout),
    .keep     (s_axis_tkeep),
    .match    (beat_ok)
  );

  assign hs        = (state_q == CHECK) && s_axis_tvalid;
  assign last_beat = ({1'b0, idx_q} == (eff_len_q - 1'b1));
  assign counted   = ({1'b0, idx_q} >= SKIP_L);

  always_comb begin
    state_n       = state_q;
    idx_n         = idx_q;
    eff_len_n     = eff_len_q;
    match_n       = match_q;
    mism_n        = mism_q;
    fei_n         = fei_q;
    fev_n         = fev_q;
    len_err_n     = len_err_q;
    pass_n        = pass_q;
    ref_en        = 1'b0;
    ref_addr      = '0;
    s_axis_tready = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          eff_len_n = (frame_len > DEPTH_L) ? DEPTH_L : frame_len;
          idx_n     = '0;
          match_n   = '0;
          mism_n    = '0;
          fei_n     = '0;
          fev_n     = 1'b0;
          len_err_n = 1'b0;
          pass_n    = 1'b0;
          if (frame_len == '0) begin
            len_err_n = 1'b1;
            state_n   = DONE;
          end else begin
            state_n   = PRIME;
          end
        end
      end

      PRIME: begin
        ref_en   = 1'b1;
        ref_addr = '0;
        state_n  = CHECK;
      end

      CHECK: begin
        s_axis_tready = 1'b1;
        if (hs) begin
          if (counted) begin
            if (beat_ok) begin
              match_n = match_q + 1'b1;
            end else begin
              mism_n = mism_q + 1'b1;
              if (!fev_q) begin
                fei_n = idx_q;
                fev_n = 1'b1;
              end
            end
          end
          // Fetch the next golden beat while this one is being consumed so
          // ref_dout is ready for back-to-back beats.
          if (!last_beat && !s_axis_tlast) begin
            ref_en   = 1'b1;
            ref_addr = idx_q + 1'b1;
          end
          if (last_beat) begin
            state_n = DONE;
            if (!s_axis_tlast) len_err_n = 1'b1;
          end else if (s_axis_tlast) begin
            len_err_n = 1'b1;
            state_n   = DONE;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Verdict is formed on entry to DONE so it is final alongside done.
    if ((state_n == DONE) && (state_q != DONE)) begin
      pass_n = !len_err_n && (mism_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      eff_len_q <= '0;
      match_q   <= '0;
      mism_q    <= '0;
      fei_q     <= '0;
      fev_q     <= 1'b0;
      len_err_q <= 1'b0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      eff_len_q <= eff_len_n;
      match_q   <= match_n;
      mism_q    <= mism_n;
      fei_q     <= fei_n;
      fev_q     <= fev_n;
      len_err_q <= len_err_n;
      pass_q    <= pass_n;
      done_q    <= (state_n == DONE);
      busy_q    <= (state_n != IDLE);
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign match_count     = match_q;
  assign mismatch_count  = mism_q;
  assign first_err_idx   = fei_q;
  assign first_err_valid = fev_q;
  assign len_err         = len_err_q;

endmodule

// File: tb/tb_axis_golden_checker.sv
module tb_axis_golden_checker;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [6:0]   frame_len;
  logic [5:0]   ref_addr, ref_addr1;
  logic         ref_en, ref_en1;
  logic [127:0] ref_dout;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast, tvalid;
  logic         tready, tready1;
  logic         busy0, done0, pass0, fev0, lerr0;
  logic         busy1, done1, pass1, fev1, lerr1;
  logic [6:0]   mc0, mmc0, mc1, mmc1;
  logic [5:0]   fei0, fei1;

  always #5 clk = ~clk;

  axis_golden_checker #(.DATA_W(128), .DEPTH(64), .SKIP_BEATS(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .ref_addr(ref_addr), .ref_en(ref_en), .ref_dout(ref_dout),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .busy(busy0), .done(done0), .pass(pass0),
    .match_count(mc0), .mismatch_count(mmc0),
    .first_err_idx(fei0), .first_err_valid(fev0), .len_err(lerr0)
  );

  axis_golden_checker #(.DATA_W(128), .DEPTH(64), .SKIP_BEATS(1)) u_dut_skip (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .ref_addr(ref_addr1), .ref_en(ref_en1), .ref_dout(ref_dout),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready1),
    .busy(busy1), .done(done1), .pass(pass1),
    .match_count(mc1), .mismatch_count(mmc1),
    .first_err_idx(fei1), .first_err_valid(fev1), .len_err(lerr1)
  );

  function automatic logic [127:0] gold(input int i);
    logic [31:0] w;
    w = i;
    return {32'hDEAD0000 | w, 32'h12345600 + w, ~w, w * 32'h9E3779B9};
  endfunction

  // Golden memory: 1-cycle read latency, output holds while not enabled.
  logic [127:0] mem [64];
  always @(posedge clk) if (ref_en) ref_dout <= mem[ref_addr];

  logic [127:0] bdata [64];
  logic [15:0]  bkeep [64];
  logic         blast [64];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cyc, done_cnt;
  bit timed_out;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic prep_frame();
    for (int i = 0; i < 64; i++) begin
      bdata[i] = gold(i);
      bkeep[i] = 16'hFFFF;
      blast[i] = (i == 63);
    end
  endtask

  // Called at #1 after a posedge. Starts a frame and streams beats until done
  // (plus two cycles), a reset abort settles, or the cycle budget runs out.
  task automatic run_frame(input int flen, input int nsend, input int gap_pct,
                           input int rst_at, input int busy_start_at);
    int  beat, cyc, abort_cyc;
    bit  hs, aborted, bs_done;
    beat = 0; aborted = 0; bs_done = 0; abort_cyc = 0;
    done_cnt = 0; done_cyc = -1; timed_out = 0;
    frame_len = flen[6:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (1) begin
      if (done0) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (aborted && cyc >= abort_cyc + 4) break;
      if (cyc > 400) begin timed_out = 1; break; end
      rst = 1'b0;
      if (!aborted && beat == rst_at) begin
        rst = 1'b1; aborted = 1; abort_cyc = cyc;
      end
      if (!bs_done && busy_start_at >= 0 && beat == busy_start_at) begin
        start = 1'b1; frame_len = 7'd5; bs_done = 1;
      end
      if (!aborted && beat < nsend && $urandom_range(0, 99) >= gap_pct) begin
        tvalid = 1'b1;
        tdata  = bdata[beat];
        tkeep  = bkeep[beat];
        tlast  = blast[beat];
      end else begin
        tvalid = 1'b0;
      end
      hs = tvalid && tready;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (hs) beat++;
    end
    rst = 1'b0;
    tvalid = 1'b0;
    tlast = 1'b0;
    if (rst_at < 0) chk("done_wait", int'(timed_out), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = gold(i);
    rst = 1'b1; start = 1'b0; frame_len = '0;
    tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", int'(tready), 0);
    chk("rst_ref_en", int'(ref_en), 0);
    chk("rst_ref_addr", int'(ref_addr), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_mc", int'(mc0), 0);
    chk("rst_mmc", int'(mmc0), 0);
    chk("rst_fei", int'(fei0), 0);
    chk("rst_fev", int'(fev0), 0);
    chk("rst_len_err", int'(lerr0), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean 64-beat frame, continuous valid
    prep_frame();
    run_frame(64, 64, 0, -1, -1);
    chk("clean_mc", int'(mc0), 64);
    chk("clean_mmc", int'(mmc0), 0);
    chk("clean_pass", int'(pass0), 1);
    chk("clean_len_err", int'(lerr0), 0);
    chk("clean_fev", int'(fev0), 0);
    chk("clean_done_cyc", done_cyc, 66);
    chk("clean_done_cnt", done_cnt, 1);
    chk("clean_skip_mc", int'(mc1), 63);
    chk("clean_busy_after", int'(busy0), 0);

    // Two corrupted beats
    prep_frame();
    bdata[5][7:0]     = bdata[5][7:0] ^ 8'hFF;
    bdata[9][127:120] = bdata[9][127:120] ^ 8'h01;
    run_frame(64, 64, 0, -1, -1);
    chk("corr_mmc", int'(mmc0), 2);
    chk("corr_mc", int'(mc0), 62);
    chk("corr_fei", int'(fei0), 5);
    chk("corr_fev", int'(fev0), 1);
    chk("corr_pass", int'(pass0), 0);

    // Garbage in beat 0: skipped by the SKIP_BEATS=1 instance only
    prep_frame();
    bdata[0] = ~gold(0);
    run_frame(64, 64, 0, -1, -1);
    chk("skip_mc", int'(mc1), 63);
    chk("skip_mmc", int'(mmc1), 0);
    chk("skip_pass", int'(pass1), 1);
    chk("noskip_mmc", int'(mmc0), 1);
    chk("noskip_fei", int'(fei0), 0);
    chk("noskip_fev", int'(fev0), 1);

    // tkeep masking: upper half of beat 3 corrupted but masked, beat 7 keep=0
    prep_frame();
    bdata[3] = bdata[3] ^ {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    bkeep[3] = 16'h00FF;
    bdata[7] = ~bdata[7];
    bkeep[7] = 16'h0000;
    run_frame(64, 64, 0, -1, -1);
    chk("keep_mc", int'(mc0), 64);
    chk("keep_pass", int'(pass0), 1);
    bkeep[3] = 16'hFFFF;
    run_frame(64, 64, 0, -1, -1);
    chk("keepall_mmc", int'(mmc0), 1);
    chk("keepall_fei", int'(fei0), 3);
    chk("keepall_pass", int'(pass0), 0);

    // Early tlast on beat 10
    prep_frame();
    blast[63] = 1'b0;
    blast[10] = 1'b1;
    run_frame(64, 11, 0, -1, -1);
    chk("early_done_cyc", done_cyc, 13);
    chk("early_len_err", int'(lerr0), 1);
    chk("early_total", int'(mc0) + int'(mmc0), 11);
    chk("early_pass", int'(pass0), 0);

    // Missing tlast on beat 63
    prep_frame();
    blast[63] = 1'b0;
    run_frame(64, 64, 0, -1, -1);
    chk("nolast_len_err", int'(lerr0), 1);
    chk("nolast_mc", int'(mc0), 64);
    chk("nolast_pass", int'(pass0), 0);
    chk("nolast_done_cyc", done_cyc, 66);

    // Zero-length frame
    prep_frame();
    run_frame(0, 0, 0, -1, -1);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_len_err", int'(lerr0), 1);
    chk("zero_pass", int'(pass0), 0);
    chk("zero_mc", int'(mc0), 0);

    // Oversized frame_len saturates to DEPTH
    prep_frame();
    run_frame(100, 64, 0, -1, -1);
    chk("sat_mc", int'(mc0), 64);
    chk("sat_len_err", int'(lerr0), 0);
    chk("sat_pass", int'(pass0), 1);

    // Random gaps, reset at beat 30
    prep_frame();
    run_frame(64, 64, 30, 30, -1);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_mc", int'(mc0), 0);
    chk("abort_tready", int'(tready), 0);
    chk("abort_ref_en", int'(ref_en), 0);

    // Fresh run with gaps and a start pulse while busy (must be ignored)
    run_frame(64, 64, 30, -1, 20);
    chk("rerun_done_cnt", done_cnt, 1);
    chk("rerun_mc", int'(mc0), 64);
    chk("rerun_len_err", int'(lerr0), 0);
    chk("rerun_pass", int'(pass0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
